// File: rtl/stack_memory.sv
// stack_memory: 4-entry LIFO driven by debounced-release push/pop buttons.
// Ports: clk, rst (async high), push/pop (raw buttons), din, clr_flags;
//   dout/A1/A0 (registered top), count, E (non-empty), F (full),
//   O/U (sticky overflow/underflow).
module stack_memory #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   input  logic             clr_flags,
   output logic [WIDTH-1:0] dout,
   output logic             A1,
   output logic             A0,
   output logic [2:0]       count,
   output logic             E,
   output logic             F,
   output logic             O,
   output logic             U
);

   logic [1:0]       push_sync;
   logic [1:0]       pop_sync;
   logic             push_hist;
   logic             pop_hist;
   logic             push_ev;
   logic             pop_ev;
   logic             do_push;
   logic             do_pop;
   logic             set_o;
   logic             set_u;
   logic [1:0]       top;
   logic [1:0]       idx_m2;
   logic [WIDTH-1:0] mem [4];

   // Event fires on the cycle the synchronized level falls (button release).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         push_sync <= '0;
         pop_sync  <= '0;
         push_hist <= 1'b0;
         pop_hist  <= 1'b0;
      end else begin
         push_sync <= {push_sync[0], push};
         pop_sync  <= {pop_sync[0], pop};
         push_hist <= push_sync[1];
         pop_hist  <= pop_sync[1];
      end
   end

   assign push_ev = ~push_sync[1] & push_hist;
   assign pop_ev  = ~pop_sync[1] & pop_hist;

   // Simultaneous events cancel each other completely.
   assign do_push = push_ev & ~pop_ev;
   assign do_pop  = pop_ev & ~push_ev;
   assign set_o   = do_push & count[2];
   assign set_u   = do_pop & (count == 3'd0);

   // Entry below the current top, valid when count is 2..4.
   assign idx_m2 = count[1:0] - 2'd2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) mem[i] <= '0;
         count <= '0;
         dout  <= '0;
         top   <= '0;
         O     <= 1'b0;
         U     <= 1'b0;
      end else begin
         if (do_push && !count[2]) begin
            mem[count[1:0]] <= din;
            count <= count + 3'd1;
            dout  <= din;
            top   <= count[1:0];
         end else if (do_pop && count != 3'd0) begin
            count <= count - 3'd1;
            if (count == 3'd1) begin
               dout <= '0;
               top  <= 2'd0;
            end else begin
               dout <= mem[idx_m2];
               top  <= idx_m2;
            end
         end
         // A set in the same cycle as a clear takes priority.
         O <= set_o | (O & ~clr_flags);
         U <= set_u | (U & ~clr_flags);
      end
   end

   assign A1 = top[1];
   assign A0 = top[0];
   assign E  = (count != 3'd0);
   assign F  = count[2];

endmodule

// File: tb/tb_stack_memory.sv
// tb_stack_memory: directed scoreboard bench for stack_memory.
// Drives button presses/releases and checks outputs against a LIFO model.
module tb_stack_memory;

   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic         push;
   logic         pop;
   logic [W-1:0] din;
   logic         clr_flags;
   logic [W-1:0] dout;
   logic         A1;
   logic         A0;
   logic [2:0]   count;
   logic         E;
   logic         F;
   logic         O;
   logic         U;

   stack_memory #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din),
      .clr_flags(clr_flags), .dout(dout), .A1(A1), .A0(A0),
      .count(count), .E(E), .F(F), .O(O), .U(U)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]   cnt;
      logic [W-1:0] dv;
      logic [1:0]   addr;
      logic         e;
      logic         f;
      logic         o;
      logic         u;
   } exp_t;

   exp_t         sb[$];
   logic [W-1:0] m_mem [4];
   int           m_cnt;
   logic         m_o;
   logic         m_u;
   int           checks;
   int           errors;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t snap();
      exp_t s;
      s.cnt  = 3'(m_cnt);
      s.dv   = (m_cnt == 0) ? '0 : m_mem[m_cnt-1];
      s.addr = (m_cnt == 0) ? 2'd0 : 2'(m_cnt - 1);
      s.e    = (m_cnt != 0);
      s.f    = (m_cnt == 4);
      s.o    = m_o;
      s.u    = m_u;
      return s;
   endfunction

   task automatic cmp(exp_t s, string tag);
      chk({tag, ".count"}, 32'(count), 32'(s.cnt));
      chk({tag, ".dout"}, 32'(dout), 32'(s.dv));
      chk({tag, ".addr"}, 32'({A1, A0}), 32'(s.addr));
      chk({tag, ".E"}, 32'(E), 32'(s.e));
      chk({tag, ".F"}, 32'(F), 32'(s.f));
      chk({tag, ".O"}, 32'(O), 32'(s.o));
      chk({tag, ".U"}, 32'(U), 32'(s.u));
   endtask

   task automatic model_step(bit p, bit q, logic [W-1:0] d, bit clr);
      bit so = 0;
      bit su = 0;
      if (p && !q) begin
         if (m_cnt < 4) begin
            m_mem[m_cnt] = d;
            m_cnt++;
         end else so = 1;
      end else if (q && !p) begin
         if (m_cnt > 0) m_cnt--;
         else su = 1;
      end
      m_o = so | (m_o & ~clr);
      m_u = su | (m_u & ~clr);
      sb.push_back(snap());
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_mem[i] = '0;
      m_cnt = 0;
      m_o   = 0;
      m_u   = 0;
   endtask

   task automatic pop_cmp(string tag);
      checks++;
      assert (sb.size() > 0) else begin
         errors++;
         $error("FAIL %s: observed empty scoreboard expected entry", tag);
      end
      if (sb.size() > 0) cmp(sb.pop_front(), tag);
   endtask

   // Press for hold cycles, release, and check update lands on 3rd edge.
   task automatic press(bit p, bit q, int hold, logic [W-1:0] d,
                        bit clr, string tag);
      exp_t pre;
      @(negedge clk);
      push = p;
      pop  = q;
      din  = ~d;
      repeat (hold) @(negedge clk);
      pre = snap();
      cmp(pre, {tag, ".held"});
      push = 0;
      pop  = 0;
      model_step(p, q, d, clr);
      @(negedge clk);
      cmp(pre, {tag, ".e1"});
      @(negedge clk);
      cmp(pre, {tag, ".e2"});
      din       = d;
      clr_flags = clr;
      @(negedge clk);
      clr_flags = 0;
      din       = ~d;
      pop_cmp({tag, ".upd"});
   endtask

   task automatic clr_pulse(string tag);
      @(negedge clk);
      clr_flags = 1;
      m_o = 0;
      m_u = 0;
      sb.push_back(snap());
      @(negedge clk);
      clr_flags = 0;
      pop_cmp(tag);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1;
      push      = 0;
      pop       = 0;
      din       = '0;
      clr_flags = 0;
      model_reset();
      repeat (3) @(negedge clk);
      cmp(snap(), "reset");
      rst = 0;

      press(1, 0, 3, 4'd1, 0, "push1");
      press(1, 0, 3, 4'd2, 0, "push2");
      press(1, 0, 4, 4'd3, 0, "push3");
      press(1, 0, 3, 4'd4, 0, "push4");
      press(1, 0, 3, 4'd9, 0, "over");
      clr_pulse("clr_o");

      press(0, 1, 3, 4'd0, 0, "pop1");
      press(0, 1, 3, 4'd0, 0, "pop2");
      press(0, 1, 5, 4'd0, 0, "pop3");
      press(0, 1, 3, 4'd0, 0, "pop4");
      press(0, 1, 3, 4'd0, 0, "under");
      press(0, 1, 3, 4'd0, 1, "setwins");
      clr_pulse("clr_u");

      press(1, 0, 50, 4'd5, 0, "long");
      press(1, 1, 4, 4'd0, 0, "both");
      press(1, 0, 3, 4'd6, 0, "push6");

      @(negedge clk);
      #2 rst = 1;
      #1;
      model_reset();
      cmp(snap(), "asyncrst");
      @(negedge clk);
      rst = 0;

      press(1, 0, 3, 4'd7, 0, "postrst");
      press(0, 1, 3, 4'd0, 0, "postpop");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/stack_memory.md
STACK_MEMORY -- requirements
Module: stack_memory

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 4, data bits per stack entry; depth is fixed at 4 entries.
REQ-002 The block SHALL have the port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have the port push, input, 1, raw push-button level, asynchronous to clk.
REQ-005 The block SHALL have the port pop, input, 1, raw pop-button level, asynchronous to clk.
REQ-006 The block SHALL have the port din, input, WIDTH, data written on an accepted push.
REQ-007 The block SHALL have the port clr_flags, input, 1, synchronous clear of the O and U sticky flags.
REQ-008 The block SHALL have the port dout, output, WIDTH, registered top-of-stack value.
REQ-009 The block SHALL have the port A1, output, 1, top-entry address MSB.
REQ-010 The block SHALL have the port A0, output, 1, top-entry address LSB.
REQ-011 The block SHALL have the port count, output, 3, occupied entries (0-4).
REQ-012 The block SHALL have the port E, output, 1, non-empty indicator (count != 0).
REQ-013 The block SHALL have the port F, output, 1, full indicator (count == 4).
REQ-014 The block SHALL have the port O, output, 1, sticky overflow (push attempted while full).
REQ-015 The block SHALL have the port U, output, 1, sticky underflow (pop attempted while empty).

Function
REQ-016 push and pop SHALL each pass through a 2-flop synchronizer plus one history flop.
REQ-017 A push event SHALL be one-cycle: synchronized push low while its history flop is high (falling edge = button release); pop events SHALL be detected the same way.
REQ-018 The stack update for an event SHALL occur on the 3rd rising clk edge at which the raw input is sampled low; exactly one event SHALL occur per release, however long the press.
REQ-019 A push event with count<4 SHALL write din into mem[count] and increment count.
REQ-020 A push event with count==4 SHALL leave mem and count unchanged and set O.
REQ-021 A pop event with count>0 SHALL decrement count; mem is not cleared.
REQ-022 A pop event with count==0 SHALL leave state unchanged and set U.
REQ-023 Push and pop events in the same cycle SHALL both be ignored: no state change, no flag change.
REQ-024 dout, A1 and A0 SHALL be registered: when count>0, dout=mem[count-1] and {A1,A0}=count-1; when count==0, dout=0 and {A1,A0}=2'b00. They SHALL be valid on the same edge count changes.
REQ-025 E, F and count SHALL be consistent with each other on every cycle.
REQ-026 O and U SHALL hold once set until clr_flags is high at a clock edge or until reset.
REQ-027 If clr_flags and a flag-setting event occur in the same cycle, the flag SHALL end set (set wins).
REQ-028 din SHALL be sampled on the update edge, not at button press time.

Reset
REQ-029 rst high SHALL immediately, without waiting for clk, force: count=0, all mem entries=0, dout=0, A1=A0=0, E=0, F=0, O=0, U=0, and all synchronizer and history flops=0.
REQ-030 A press in progress when rst deasserts SHALL produce no event until that button's next release, because the history flop is 0.
REQ-031 Reset asserted mid-update SHALL win; no partial write SHALL survive.

Verification
REQ-032 After reset, push/release 4 times with din=1,2,3,4 -> count=4, F=1, dout=4, {A1,A0}=11, O=0.
REQ-033 When full, a 5th push with din=9 -> count=4, dout=4, O=1; then clr_flags pulse -> O=0.
REQ-034 Four pops from full -> dout sequence 3,2,1,0, count=0, E=0; a 5th pop sets U=1.
REQ-035 Hold push for 50 cycles, then release -> exactly one write, on the 3rd edge after release.
REQ-036 Release push and pop together -> no change to count, dout, O or U.
REQ-037 Assert rst asynchronously between clock edges with count=2 -> all outputs 0 before the next clk edge.
